// File: rtl/rs_pool_agesel.sv
// Reservation-station pool. Entries snoop the CDB for pending operands, and the oldest
// ready op (age measured from the ROB head) moves into a single valid/ready dispatch register.
module rs_pool_agesel #(
    parameter int RS_DEPTH = 16,
    parameter int TAG_W    = 5,
    parameter int XLEN     = 32,
    parameter int OP_W     = 6,
    parameter int CDB_CH   = 3
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic                           rdy_in,
    input  logic                           flush_in,
    input  logic [TAG_W-1:0]               rob_head_in,
    input  logic                           iss_valid_in,
    output logic                           iss_ready_out,
    input  logic [OP_W-1:0]                iss_op_in,
    input  logic [31:0]                    iss_inst_in,
    input  logic [31:0]                    iss_pc_in,
    input  logic [XLEN-1:0]                iss_imm_in,
    input  logic [TAG_W-1:0]               iss_tag_in,
    input  logic                           iss_qj_valid_in,
    input  logic [TAG_W-1:0]               iss_qj_in,
    input  logic [XLEN-1:0]                iss_vj_in,
    input  logic                           iss_qk_valid_in,
    input  logic [TAG_W-1:0]               iss_qk_in,
    input  logic [XLEN-1:0]                iss_vk_in,
    input  logic [CDB_CH-1:0]              cdb_valid_in,
    input  logic [CDB_CH*TAG_W-1:0]        cdb_tag_in,
    input  logic [CDB_CH*XLEN-1:0]         cdb_data_in,
    output logic                           disp_valid_out,
    input  logic                           disp_ready_in,
    output logic [OP_W-1:0]                disp_op_out,
    output logic [31:0]                    disp_inst_out,
    output logic [31:0]                    disp_pc_out,
    output logic [XLEN-1:0]                disp_vj_out,
    output logic [XLEN-1:0]                disp_vk_out,
    output logic [XLEN-1:0]                disp_imm_out,
    output logic [TAG_W-1:0]               disp_tag_out,
    output logic [$clog2(RS_DEPTH+1)-1:0]  free_cnt_out
);
    localparam int CNT_W = $clog2(RS_DEPTH + 1);
    localparam int IDX_W = $clog2(RS_DEPTH);

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [31:0]      inst;
        logic [31:0]      pc;
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             qj_pend;
        logic [TAG_W-1:0] qj;
        logic [XLEN-1:0]  vj;
        logic             qk_pend;
        logic [TAG_W-1:0] qk;
        logic [XLEN-1:0]  vk;
    } entry_t;

    entry_t              ent_q [RS_DEPTH];
    entry_t              ent_d [RS_DEPTH];
    entry_t              iss_ent;
    logic [RS_DEPTH-1:0] valid_q;
    logic [RS_DEPTH-1:0] valid_d;
    logic [RS_DEPTH-1:0] elig;
    logic [TAG_W-1:0]    age [RS_DEPTH];
    logic [TAG_W-1:0]    best_age;
    logic [IDX_W-1:0]    free_idx;
    logic [IDX_W-1:0]    sel_idx;
    logic                sel_found;
    logic                iss_fire;
    logic                disp_load;

    // Returns {pending, value}; channels are scanned high to low so the lowest match wins.
    function automatic logic [XLEN:0] snoop(input logic pend, input logic [TAG_W-1:0] q,
                                            input logic [XLEN-1:0] v);
        logic [XLEN:0] res;
        res = {pend, v};
        for (int c = CDB_CH - 1; c >= 0; c--) begin
            if (pend && cdb_valid_in[c] && (cdb_tag_in[c*TAG_W +: TAG_W] == q))
                res = {1'b0, cdb_data_in[c*XLEN +: XLEN]};
        end
        return res;
    endfunction

    always_comb begin
        free_cnt_out = '0;
        free_idx     = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_cnt_out = free_cnt_out + CNT_W'(1);
                free_idx     = IDX_W'(i);
            end
        end
    end

    assign iss_ready_out = (free_cnt_out != '0);
    assign iss_fire      = iss_valid_in && iss_ready_out;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        best_age  = '0;
        elig      = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            elig[i] = valid_q[i] && !ent_q[i].qj_pend && !ent_q[i].qk_pend;
            age[i]  = ent_q[i].tag - rob_head_in;
            if (elig[i] && (!sel_found || (age[i] < best_age))) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                best_age  = age[i];
            end
        end
    end

    assign disp_load = sel_found && (!disp_valid_out || disp_ready_in);

    always_comb begin
        iss_ent      = '0;
        iss_ent.op   = iss_op_in;
        iss_ent.inst = iss_inst_in;
        iss_ent.pc   = iss_pc_in;
        iss_ent.imm  = iss_imm_in;
        iss_ent.tag  = iss_tag_in;
        iss_ent.qj   = iss_qj_in;
        iss_ent.qk   = iss_qk_in;
        {iss_ent.qj_pend, iss_ent.vj} = snoop(iss_qj_valid_in, iss_qj_in, iss_vj_in);
        {iss_ent.qk_pend, iss_ent.vk} = snoop(iss_qk_valid_in, iss_qk_in, iss_vk_in);
    end

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < RS_DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            {ent_d[i].qj_pend, ent_d[i].vj} = snoop(ent_q[i].qj_pend, ent_q[i].qj, ent_q[i].vj);
            {ent_d[i].qk_pend, ent_d[i].vk} = snoop(ent_q[i].qk_pend, ent_q[i].qk, ent_q[i].vk);
            if (disp_load && (sel_idx == IDX_W'(i)))
                valid_d[i] = 1'b0;
            if (iss_fire && (free_idx == IDX_W'(i))) begin
                ent_d[i]   = iss_ent;
                valid_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q        <= '0;
            for (int i = 0; i < RS_DEPTH; i++)
                ent_q[i] <= '0;
            disp_valid_out <= 1'b0;
            disp_op_out    <= '0;
            disp_inst_out  <= '0;
            disp_pc_out    <= '0;
            disp_vj_out    <= '0;
            disp_vk_out    <= '0;
            disp_imm_out   <= '0;
            disp_tag_out   <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                valid_q        <= '0;
                disp_valid_out <= 1'b0;
            end else begin
                valid_q <= valid_d;
                for (int i = 0; i < RS_DEPTH; i++)
                    ent_q[i] <= ent_d[i];
                if (disp_load) begin
                    disp_valid_out <= 1'b1;
                    disp_op_out    <= ent_q[sel_idx].op;
                    disp_inst_out  <= ent_q[sel_idx].inst;
                    disp_pc_out    <= ent_q[sel_idx].pc;
                    disp_vj_out    <= ent_q[sel_idx].vj;
                    disp_vk_out    <= ent_q[sel_idx].vk;
                    disp_imm_out   <= ent_q[sel_idx].imm;
                    disp_tag_out   <= ent_q[sel_idx].tag;
                end else if (disp_ready_in) begin
                    disp_valid_out <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_rs_pool_agesel.sv
// Bench for rs_pool_agesel: directed scenarios with literal expectations, then random
// traffic, all compared each cycle against a slot-array model of the pool.
module tb_rs_pool_agesel;
    localparam int RS_DEPTH = 16;
    localparam int TAG_W    = 5;
    localparam int XLEN     = 32;
    localparam int OP_W     = 6;
    localparam int CDB_CH   = 3;
    localparam int CNT_W    = $clog2(RS_DEPTH + 1);
    localparam int ROB_SZ   = 1 << TAG_W;

    logic                    clk_in = 1'b0;
    logic                    rst_n_in, rdy_in, flush_in;
    logic [TAG_W-1:0]        rob_head_in;
    logic                    iss_valid_in, iss_ready_out;
    logic [OP_W-1:0]         iss_op_in;
    logic [31:0]             iss_inst_in, iss_pc_in;
    logic [XLEN-1:0]         iss_imm_in, iss_vj_in, iss_vk_in;
    logic [TAG_W-1:0]        iss_tag_in, iss_qj_in, iss_qk_in;
    logic                    iss_qj_valid_in, iss_qk_valid_in;
    logic [CDB_CH-1:0]       cdb_valid_in;
    logic [CDB_CH*TAG_W-1:0] cdb_tag_in;
    logic [CDB_CH*XLEN-1:0]  cdb_data_in;
    logic                    disp_valid_out, disp_ready_in;
    logic [OP_W-1:0]         disp_op_out;
    logic [31:0]             disp_inst_out, disp_pc_out;
    logic [XLEN-1:0]         disp_vj_out, disp_vk_out, disp_imm_out;
    logic [TAG_W-1:0]        disp_tag_out;
    logic [CNT_W-1:0]        free_cnt_out;

    always #5 clk_in = ~clk_in;

    rs_pool_agesel #(.RS_DEPTH(RS_DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .OP_W(OP_W),
                     .CDB_CH(CDB_CH)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .rob_head_in(rob_head_in), .iss_valid_in(iss_valid_in), .iss_ready_out(iss_ready_out),
        .iss_op_in(iss_op_in), .iss_inst_in(iss_inst_in), .iss_pc_in(iss_pc_in),
        .iss_imm_in(iss_imm_in), .iss_tag_in(iss_tag_in), .iss_qj_valid_in(iss_qj_valid_in),
        .iss_qj_in(iss_qj_in), .iss_vj_in(iss_vj_in), .iss_qk_valid_in(iss_qk_valid_in),
        .iss_qk_in(iss_qk_in), .iss_vk_in(iss_vk_in), .cdb_valid_in(cdb_valid_in),
        .cdb_tag_in(cdb_tag_in), .cdb_data_in(cdb_data_in), .disp_valid_out(disp_valid_out),
        .disp_ready_in(disp_ready_in), .disp_op_out(disp_op_out), .disp_inst_out(disp_inst_out),
        .disp_pc_out(disp_pc_out), .disp_vj_out(disp_vj_out), .disp_vk_out(disp_vk_out),
        .disp_imm_out(disp_imm_out), .disp_tag_out(disp_tag_out), .free_cnt_out(free_cnt_out)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: one record per slot; dispatch register kept as a record too.
    typedef struct packed {
        logic             v;
        logic [OP_W-1:0]  op;
        logic [31:0]      inst;
        logic [31:0]      pc;
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             pj;
        logic [TAG_W-1:0] qj;
        logic [XLEN-1:0]  vj;
        logic             pk;
        logic [TAG_W-1:0] qk;
        logic [XLEN-1:0]  vk;
    } ment_t;

    ment_t m [RS_DEPTH];
    ment_t n [RS_DEPTH];
    ment_t m_d, n_d;
    logic  m_dv, n_dv;
    bit    cmp_en = 1'b0;

    function automatic int m_free();
        int f = 0;
        for (int i = 0; i < RS_DEPTH; i++) if (!m[i].v) f++;
        return f;
    endfunction

    function automatic logic [XLEN:0] m_snoop(input logic p, input logic [TAG_W-1:0] q,
                                              input logic [XLEN-1:0] v);
        if (p) begin
            for (int c = 0; c < CDB_CH; c++)
                if (cdb_valid_in[c] && (cdb_tag_in[c*TAG_W +: TAG_W] == q))
                    return {1'b0, cdb_data_in[c*XLEN +: XLEN]};
        end
        return {p, v};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RS_DEPTH; i++) begin m[i] = '0; n[i] = '0; end
        m_d = '0; n_d = '0; m_dv = 1'b0; n_dv = 1'b0;
    endtask

    task automatic model_next();
        int nfree, slot, key, best, s;
        logic [XLEN:0] r;
        ment_t e;
        n = m; n_d = m_d; n_dv = m_dv;
        if (!rst_n_in || !rdy_in) return;
        if (flush_in) begin
            for (int i = 0; i < RS_DEPTH; i++) n[i].v = 1'b0;
            n_dv = 1'b0;
            return;
        end
        nfree = 0; slot = -1; best = -1;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!m[i].v) begin
                nfree++;
                if (slot < 0) slot = i;
            end else if (!m[i].pj && !m[i].pk) begin
                // age-major, index-minor key: smallest key is the winner
                key = ((int'(m[i].tag) - int'(rob_head_in) + ROB_SZ) % ROB_SZ) * RS_DEPTH + i;
                if (best < 0 || key < best) best = key;
            end
        end
        if (best >= 0 && (!m_dv || disp_ready_in)) begin
            s = best % RS_DEPTH;
            n_d = m[s]; n_dv = 1'b1; n[s].v = 1'b0;
        end else if (disp_ready_in) begin
            n_dv = 1'b0;
        end
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (n[i].v) begin
                r = m_snoop(n[i].pj, n[i].qj, n[i].vj); n[i].pj = r[XLEN]; n[i].vj = r[XLEN-1:0];
                r = m_snoop(n[i].pk, n[i].qk, n[i].vk); n[i].pk = r[XLEN]; n[i].vk = r[XLEN-1:0];
            end
        end
        if (iss_valid_in && nfree > 0) begin
            e = '0;
            e.v = 1'b1; e.op = iss_op_in; e.inst = iss_inst_in; e.pc = iss_pc_in;
            e.imm = iss_imm_in; e.tag = iss_tag_in; e.qj = iss_qj_in; e.qk = iss_qk_in;
            r = m_snoop(iss_qj_valid_in, iss_qj_in, iss_vj_in); e.pj = r[XLEN]; e.vj = r[XLEN-1:0];
            r = m_snoop(iss_qk_valid_in, iss_qk_in, iss_vk_in); e.pk = r[XLEN]; e.vk = r[XLEN-1:0];
            n[slot] = e;
        end
    endtask

    task automatic cyc();
        model_next();
        @(posedge clk_in);
        m = n; m_d = n_d; m_dv = n_dv;
        #1;
    endtask

    always @(negedge clk_in) begin
        if (cmp_en) begin
            chk("disp_valid", disp_valid_out, m_dv);
            chk("free_cnt", free_cnt_out, m_free());
            chk("iss_ready", iss_ready_out, m_free() != 0);
            if (m_dv) begin
                chk("disp_op", disp_op_out, m_d.op);
                chk("disp_inst", disp_inst_out, m_d.inst);
                chk("disp_pc", disp_pc_out, m_d.pc);
                chk("disp_vj", disp_vj_out, m_d.vj);
                chk("disp_vk", disp_vk_out, m_d.vk);
                chk("disp_imm", disp_imm_out, m_d.imm);
                chk("disp_tag", disp_tag_out, m_d.tag);
            end
        end
    end

    task automatic set_idle();
        rdy_in = 1'b1; flush_in = 1'b0; disp_ready_in = 1'b1;
        iss_valid_in = 1'b0; iss_qj_valid_in = 1'b0; iss_qk_valid_in = 1'b0;
        cdb_valid_in = '0;
    endtask

    task automatic idle(input int cycles);
        set_idle();
        repeat (cycles) cyc();
    endtask

    task automatic issue(input int tag, input bit qjv, input int qj, input logic [31:0] vj,
                         input bit qkv, input int qk, input logic [31:0] vk);
        iss_valid_in = 1'b1;
        iss_op_in = OP_W'(tag + 1);
        iss_inst_in = 32'h0000_0013 + 32'(tag << 7);
        iss_pc_in = 32'h0000_1000 + 32'(tag * 4);
        iss_imm_in = 32'(tag * 3);
        iss_tag_in = TAG_W'(tag);
        iss_qj_valid_in = qjv; iss_qj_in = TAG_W'(qj); iss_vj_in = vj;
        iss_qk_valid_in = qkv; iss_qk_in = TAG_W'(qk); iss_vk_in = vk;
    endtask

    task automatic cdb(input int c, input int tag, input logic [31:0] data);
        cdb_valid_in[c] = 1'b1;
        cdb_tag_in[c*TAG_W +: TAG_W] = TAG_W'(tag);
        cdb_data_in[c*XLEN +: XLEN] = data;
    endtask

    initial begin
        rst_n_in = 1'b0; rob_head_in = '0;
        iss_op_in = '0; iss_inst_in = '0; iss_pc_in = '0; iss_imm_in = '0; iss_tag_in = '0;
        iss_qj_in = '0; iss_qk_in = '0; iss_vj_in = '0; iss_vk_in = '0;
        cdb_tag_in = '0; cdb_data_in = '0;
        set_idle();
        model_reset();
        cmp_en = 1'b1;
        cyc(); cyc();
        chk("rst_disp_valid", disp_valid_out, 0);
        chk("rst_free_cnt", free_cnt_out, 16);
        chk("rst_iss_ready", iss_ready_out, 1);
        chk("rst_disp_vj", disp_vj_out, 0);
        rst_n_in = 1'b1;
        cyc();

        // simple op, both operands ready
        issue(3, 0, 0, 32'd5, 0, 0, 32'd7);
        cyc();
        set_idle();
        cyc();
        chk("t1_valid", disp_valid_out, 1);
        chk("t1_vj", disp_vj_out, 5);
        chk("t1_vk", disp_vk_out, 7);
        chk("t1_tag", disp_tag_out, 3);
        chk("t1_free", free_cnt_out, 16);
        idle(2);

        // later wakeup; ch1 and ch2 both carry tag 9, ch1 wins
        issue(4, 1, 9, 32'h1111, 0, 0, 32'd1);
        cyc();
        set_idle();
        cdb(1, 9, 32'hDEAD); cdb(2, 9, 32'h0BAD);
        cyc();
        cdb_valid_in = '0;
        cyc();
        chk("t2_valid", disp_valid_out, 1);
        chk("t2_vj", disp_vj_out, 32'hDEAD);
        chk("t2_tag", disp_tag_out, 4);
        idle(2);

        // issue-cycle capture; ch0 wins over ch1
        issue(6, 1, 9, 32'h1111, 0, 0, 32'd2);
        cdb(0, 9, 32'hBEEF); cdb(1, 9, 32'hDEAD);
        cyc();
        set_idle();
        cyc();
        chk("t2b_vj", disp_vj_out, 32'hBEEF);
        chk("t2b_tag", disp_tag_out, 6);
        idle(2);

        // wrap-around age ordering around rob_head=30
        rob_head_in = TAG_W'(30);
        issue(2, 1, 20, 0, 0, 0, 32'd2);  cyc();
        issue(31, 1, 20, 0, 0, 0, 32'd3); cyc();
        issue(0, 1, 20, 0, 0, 0, 32'd4);  cyc();
        set_idle();
        cdb(0, 20, 32'h20);
        cyc();
        cdb_valid_in = '0;
        cyc(); chk("t3_first", disp_tag_out, 31);
        cyc(); chk("t3_second", disp_tag_out, 0);
        cyc(); chk("t3_third", disp_tag_out, 2);
        idle(3);

        // fill the pool, then hold dispatch under backpressure
        rob_head_in = '0;
        disp_ready_in = 1'b0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            issue(i, 1, 25, 0, 0, 0, 32'(i));
            cyc();
        end
        issue(20, 0, 0, 32'd1, 0, 0, 32'd1);
        chk("t4_full_ready", iss_ready_out, 0);
        chk("t4_full_free", free_cnt_out, 0);
        cdb(0, 25, 32'h25);
        cyc();
        cdb_valid_in = '0;
        cyc();
        iss_valid_in = 1'b0;
        chk("t4_refused_free", free_cnt_out, 1);
        chk("t4_load_tag", disp_tag_out, 0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t4_hold_tag", disp_tag_out, 0);
            chk("t4_hold_vj", disp_vj_out, 32'h25);
        end
        disp_ready_in = 1'b1;
        cyc();
        chk("t4_next_tag", disp_tag_out, 1);
        idle(20);

        // flush beats issue and dispatch
        disp_ready_in = 1'b0;
        issue(1, 0, 0, 32'd1, 0, 0, 32'd1); cyc();
        iss_valid_in = 1'b0; cyc();
        for (int i = 0; i < 10; i++) begin
            issue(10 + i, 1, 26, 0, 0, 0, 0);
            cyc();
        end
        chk("t5_pre_free", free_cnt_out, 6);
        chk("t5_pre_valid", disp_valid_out, 1);
        flush_in = 1'b1;
        issue(5, 0, 0, 32'd9, 0, 0, 32'd9);
        cyc();
        chk("t5_free", free_cnt_out, 16);
        chk("t5_valid", disp_valid_out, 0);
        flush_in = 1'b0; iss_valid_in = 1'b0;
        cyc();
        chk("t5_dropped", free_cnt_out, 16);
        idle(2);

        // stall freezes everything, including a wakeup that is then missed
        issue(8, 1, 7, 0, 0, 0, 32'd8); cyc();
        rdy_in = 1'b0;
        issue(9, 0, 0, 32'd1, 0, 0, 32'd1);
        cdb(2, 7, 32'h77);
        cyc(); cyc();
        chk("t6_stall_free", free_cnt_out, 15);
        chk("t6_stall_valid", disp_valid_out, 0);
        set_idle();
        cyc(); cyc();
        chk("t6_missed_wake", disp_valid_out, 0);
        chk("t6_free", free_cnt_out, 15);

        // asynchronous reset between edges
        disp_ready_in = 1'b0;
        issue(3, 0, 0, 32'd4, 0, 0, 32'd4); cyc();
        iss_valid_in = 1'b0; cyc();
        chk("t6_pre_valid", disp_valid_out, 1);
        #2;
        rst_n_in = 1'b0;
        model_reset();
        #1;
        chk("arst_valid", disp_valid_out, 0);
        chk("arst_free", free_cnt_out, 16);
        chk("arst_ready", iss_ready_out, 1);
        chk("arst_tag", disp_tag_out, 0);
        cyc();
        rst_n_in = 1'b1;
        idle(2);

        // random traffic; small tag set so CDB hits pending operands often
        for (int k = 0; k < 3000; k++) begin
            rdy_in = ($urandom_range(99) < 90);
            flush_in = ($urandom_range(99) < 2);
            if ($urandom_range(99) < 5) rob_head_in = TAG_W'($urandom);
            iss_valid_in = ($urandom_range(99) < 60);
            iss_op_in = OP_W'($urandom);
            iss_inst_in = $urandom;
            iss_pc_in = $urandom;
            iss_imm_in = $urandom;
            iss_tag_in = TAG_W'($urandom);
            iss_qj_valid_in = ($urandom_range(99) < 40);
            iss_qj_in = TAG_W'($urandom_range(7));
            iss_vj_in = $urandom;
            iss_qk_valid_in = ($urandom_range(99) < 40);
            iss_qk_in = TAG_W'($urandom_range(7));
            iss_vk_in = $urandom;
            cdb_valid_in = CDB_CH'($urandom);
            for (int c = 0; c < CDB_CH; c++) begin
                cdb_tag_in[c*TAG_W +: TAG_W] = TAG_W'($urandom_range(7));
                cdb_data_in[c*XLEN +: XLEN] = $urandom;
            end
            disp_ready_in = ($urandom_range(99) < 70);
            cyc();
        end
        idle(2);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
